apb_master_bridge: RTL

//  APB3 initiator for the processor's slave APB register port (S_PSEL..S_PSLVERR).

---
 rtl/apb_master_bridge.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/apb_master_bridge.sv
// APB3 initiator: turns single host register requests into one APB transfer each
// and returns read data, slave error and timeout status on a response channel.
module apb_master_bridge #(
    parameter int C_ADDR_WIDTH = 16,
    parameter int C_DATA_WIDTH = 32,
    parameter int C_TIMEOUT    = 256
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    REQ_VALID,
    output logic                    REQ_READY,
    input  logic                    REQ_WRITE,
    input  logic [C_ADDR_WIDTH-1:0] REQ_ADDR,
    input  logic [C_DATA_WIDTH-1:0] REQ_WDATA,
    output logic                    RSP_VALID,
    input  logic                    RSP_READY,
    output logic [C_DATA_WIDTH-1:0] RSP_RDATA,
    output logic                    RSP_ERR,
    output logic                    RSP_TIMEOUT,
    output logic                    M_PSEL,
    output logic                    M_PENABLE,
    output logic                    M_PWRITE,
    output logic [C_ADDR_WIDTH-1:0] M_PADDR,
    output logic [C_DATA_WIDTH-1:0] M_PWDATA,
    input  logic [C_DATA_WIDTH-1:0] M_PRDATA,
    input  logic                    M_PREADY,
    input  logic                    M_PSLVERR,
    output logic                    BUSY
);

    // A zero timeout disables the abort path; keep the counter at least one bit wide.
    localparam int              CW         = (C_TIMEOUT > 0) ? $clog2(C_TIMEOUT + 1) : 1;
    localparam int              TMO_LAST_I = (C_TIMEOUT > 0) ? (C_TIMEOUT - 1) : 0;
    localparam logic [CW-1:0]   TMO_LAST   = CW'(TMO_LAST_I);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO   = CW'(0);
    localparam bit              TMO_EN     = (C_TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  state_r;
    logic                    req_ready_r;
    logic                    rsp_valid_r;
    logic [C_DATA_WIDTH-1:0] rsp_rdata_r;
    logic                    rsp_err_r;
    logic                    rsp_timeout_r;
    logic                    psel_r;
    logic                    penable_r;
    logic                    pwrite_r;
    logic [C_ADDR_WIDTH-1:0] paddr_r;
    logic [C_DATA_WIDTH-1:0] pwdata_r;
    logic                    busy_r;
    logic [CW-1:0]           cnt_r;

    // Transfer sequencer: every output is a register updated here.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= ST_IDLE;
            req_ready_r   <= 1'b0;
            rsp_valid_r   <= 1'b0;
            rsp_rdata_r   <= {C_DATA_WIDTH{1'b0}};
            rsp_err_r     <= 1'b0;
            rsp_timeout_r <= 1'b0;
            psel_r        <= 1'b0;
            penable_r     <= 1'b0;
            pwrite_r      <= 1'b0;
            paddr_r       <= {C_ADDR_WIDTH{1'b0}};
            pwdata_r      <= {C_DATA_WIDTH{1'b0}};
            busy_r        <= 1'b0;
            cnt_r         <= CNT_ZERO;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // REQ_READY rises one cycle after reset release, so gate on the register.
                    if (REQ_VALID && req_ready_r) begin
                        pwrite_r    <= REQ_WRITE;
                        paddr_r     <= REQ_ADDR;
                        pwdata_r    <= REQ_WDATA;
                        psel_r      <= 1'b1;
                        req_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_SETUP;
                    end else begin
                        req_ready_r <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    penable_r <= 1'b1;
                    cnt_r     <= CNT_ZERO;
                    state_r   <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (M_PREADY) begin
                        rsp_rdata_r   <= (!pwrite_r && !M_PSLVERR) ? M_PRDATA : {C_DATA_WIDTH{1'b0}};
                        rsp_err_r     <= M_PSLVERR;
                        rsp_timeout_r <= 1'b0;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= ST_RESP;
                    end else if (TMO_EN && (cnt_r == TMO_LAST)) begin
                        rsp_rdata_r   <= {C_DATA_WIDTH{1'b0}};
                        rsp_err_r     <= 1'b1;
                        rsp_timeout_r <= 1'b1;
                        psel_r        <= 1'b0;
                        penable_r     <= 1'b0;
                        rsp_valid_r   <= 1'b1;
                        state_r       <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_RESP: begin
                    if (RSP_READY) begin
                        rsp_valid_r <= 1'b0;
                        req_ready_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        rsp_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    req_ready_r <= 1'b0;
                    rsp_valid_r <= 1'b0;
                    psel_r      <= 1'b0;
                    penable_r   <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign REQ_READY   = req_ready_r;
    assign RSP_VALID   = rsp_valid_r;
    assign RSP_RDATA   = rsp_rdata_r;
    assign RSP_ERR     = rsp_err_r;
    assign RSP_TIMEOUT = rsp_timeout_r;
    assign M_PSEL      = psel_r;
    assign M_PENABLE   = penable_r;
    assign M_PWRITE    = pwrite_r;
    assign M_PADDR     = paddr_r;
    assign M_PWDATA    = pwdata_r;
    assign BUSY        = busy_r;

endmodule
